// File: rtl/gcd_pkg.sv
// Shared types and control-word constants for the subtract/swap GCD controller.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic wea;
        logic web;
        logic mux1;
        logic mux2;
        logic aluctl;
    } ctrl_word_t;

    // Field order: wea, web, mux1, mux2, aluctl
    localparam ctrl_word_t CTRL_HOLD = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam ctrl_word_t CTRL_LOAD = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam ctrl_word_t CTRL_SUB  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam ctrl_word_t CTRL_SWAP = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

endpackage

// File: rtl/gcd_sub_ctrl_if.sv
// Request/result handshake bundle between a client and gcd_sub_ctrl.
interface gcd_sub_ctrl_if #(
    parameter int N = 32
) ();
    logic         start;
    logic [N-1:0] op_x;
    logic [N-1:0] op_y;
    logic         busy;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] result;

    modport master (
        output start, op_x, op_y, res_ready,
        input  busy, res_valid, result
    );

    modport slave (
        input  start, op_x, op_y, res_ready,
        output busy, res_valid, result
    );
endinterface

// File: rtl/gcd_step_dec.sv
// Combinational step decoder: picks terminal, subtract or swap from the current A/B.
module gcd_step_dec
    import gcd_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         terminal,
    output ctrl_word_t   ctrl,
    output logic         swap_sel
);

    always_comb begin
        terminal = 1'b0;
        ctrl     = CTRL_HOLD;
        swap_sel = 1'b0;
        if (a == '0 || b == '0 || a == b) begin
            terminal = 1'b1;
        end else if (a > b) begin
            ctrl = CTRL_SUB;
        end else begin
            ctrl     = CTRL_SWAP;
            swap_sel = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_sub_ctrl.sv
// GCD sequencer owning the A/B registers of an external add/sub datapath.
// Optional RUN-cycle limit with err output when GCD_ITER_LIMIT_EN is defined.
module gcd_sub_ctrl
    import gcd_pkg::*;
#(
    parameter int N        = 32,
    parameter int MAX_ITER = 1024
) (
    input  logic         clock,
    input  logic         reset_n,
    gcd_sub_ctrl_if.slave bus,
    output logic         wea,
    output logic         web,
    output logic         mux1,
    output logic         mux2,
    output logic         aluctl,
    output logic [N-1:0] X,
    output logic [N-1:0] Y,
    output logic [N-1:0] A,
    output logic [N-1:0] B,
    input  logic [N-1:0] newA,
    input  logic [N-1:0] newB
`ifdef GCD_ITER_LIMIT_EN
    ,
    output logic         err
`endif
);

    state_t       state_reg, state_next;
    logic [N-1:0] a_reg, b_reg;
    logic [N-1:0] result_reg, result_next;
    ctrl_word_t   ctrl;
    logic         step_terminal;
    ctrl_word_t   step_ctrl;
    logic         step_swap;
    logic         limit_hit;

    gcd_step_dec #(.N(N)) u_step_dec (
        .a        (a_reg),
        .b        (b_reg),
        .terminal (step_terminal),
        .ctrl     (step_ctrl),
        .swap_sel (step_swap)
    );

    // A and B always take the datapath's next values; hold is expressed via wea/web.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= newA;
            b_reg      <= newB;
            result_reg <= result_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        ctrl        = CTRL_HOLD;
        X           = '0;
        Y           = '0;
        case (state_reg)
            IDLE: begin
                X        = bus.op_x;
                Y        = bus.op_y;
                ctrl.wea = bus.start;
                ctrl.web = bus.start;
                if (bus.start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (step_terminal) begin
                    result_next = a_reg | b_reg;
                    state_next  = DONE;
                end else if (limit_hit) begin
                    result_next = '0;
                    state_next  = DONE;
                end else begin
                    ctrl = step_ctrl;
                    if (step_swap) begin
                        X = b_reg;
                        Y = a_reg;
                    end
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef GCD_ITER_LIMIT_EN
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);

    logic [IW-1:0] iter_reg, iter_next;
    logic          err_reg, err_next;

    // iter_reg counts RUN cycles already completed; the MAX_ITER-th cycle aborts.
    assign limit_hit = (iter_reg == ITER_LAST);

    always_comb begin
        iter_next = iter_reg;
        err_next  = err_reg;
        if (state_reg == IDLE && bus.start) begin
            iter_next = '0;
            err_next  = 1'b0;
        end else if (state_reg == RUN) begin
            iter_next = iter_reg + 1'b1;
            if (!step_terminal && limit_hit) begin
                err_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iter_reg <= '0;
            err_reg  <= 1'b0;
        end else begin
            iter_reg <= iter_next;
            err_reg  <= err_next;
        end
    end

    assign err = err_reg;
`else
    assign limit_hit = 1'b0;
`endif

    assign wea    = ctrl.wea;
    assign web    = ctrl.web;
    assign mux1   = ctrl.mux1;
    assign mux2   = ctrl.mux2;
    assign aluctl = ctrl.aluctl;
    assign A      = a_reg;
    assign B      = b_reg;

    assign bus.busy      = (state_reg != IDLE);
    assign bus.res_valid = (state_reg == DONE);
    assign bus.result    = result_reg;

endmodule

// File: tb/tb_gcd_sub_ctrl.sv
// Self-checking bench for gcd_sub_ctrl: behavioural add/sub datapath plus Euclid reference.
module tb_gcd_sub_ctrl;
    localparam int N = 32;
`ifdef GCD_ITER_LIMIT_EN
    localparam int  LIM    = 4;
    localparam bit  LIM_EN = 1'b1;
`else
    localparam int  LIM    = 1024;
    localparam bit  LIM_EN = 1'b0;
`endif

    logic         clock;
    logic         reset_n;
    logic         wea, web, mux1, mux2, aluctl;
    logic [N-1:0] X, Y, A, B, newA, newB;
    logic         err_obs;

    int vectors    = 0;
    int miscompares = 0;

    int unsigned tr_a[$];
    int unsigned tr_b[$];

    gcd_sub_ctrl_if #(.N(N)) bus ();

    gcd_sub_ctrl #(.N(N), .MAX_ITER(LIM)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus),
        .wea     (wea),
        .web     (web),
        .mux1    (mux1),
        .mux2    (mux2),
        .aluctl  (aluctl),
        .X       (X),
        .Y       (Y),
        .A       (A),
        .B       (B),
        .newA    (newA),
        .newB    (newB)
`ifdef GCD_ITER_LIMIT_EN
        ,
        .err     (err_obs)
`endif
    );

`ifndef GCD_ITER_LIMIT_EN
    assign err_obs = 1'b0;
`endif

    // The add/sub datapath that sits downstream of the controller.
    assign newA = !wea ? A : (!mux1 ? X : (aluctl ? A - B : A + B));
    assign newB = !web ? B : (!mux2 ? Y : (aluctl ? A - B : A + B));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned ref_gcd(input int unsigned x, input int unsigned y);
        int unsigned a = x;
        int unsigned b = y;
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Register contents seen at the start of each RUN cycle.
    task automatic build_trace(input int unsigned x, input int unsigned y);
        int unsigned a = x;
        int unsigned b = y;
        int unsigned t;
        tr_a.delete();
        tr_b.delete();
        while (1) begin
            tr_a.push_back(a);
            tr_b.push_back(b);
            if (a == 0 || b == 0 || a == b) break;
            if (a > b) a = a - b;
            else begin
                t = a; a = b; b = t;
            end
        end
    endtask

    // Entered and left at a negedge with the DUT in IDLE.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input int hold);
        int k, exp_k;
        logic exp_err;
        logic [31:0] exp_res;
        build_trace(x, y);
        k       = tr_a.size();
        exp_err = LIM_EN && (k > LIM);
        exp_k   = exp_err ? LIM : k;
        exp_res = exp_err ? 32'd0 : ref_gcd(x, y);
        bus.start = 1'b1;
        bus.op_x  = x;
        bus.op_y  = y;
        @(negedge clock);
        bus.start = 1'b0;
        bus.op_x  = $urandom;
        bus.op_y  = $urandom;
        chk("busy_run", bus.busy, 1);
        for (int n = 0; n < exp_k; n++) begin
            chk("reg_a", A, tr_a[n]);
            chk("reg_b", B, tr_b[n]);
            chk("valid_early", bus.res_valid, 0);
            @(negedge clock);
        end
        chk("valid", bus.res_valid, 1);
        chk("result", bus.result, exp_res);
        chk("busy_done", bus.busy, 1);
        if (LIM_EN) chk("err", err_obs, exp_err);
        for (int h = 0; h < hold; h++) begin
            bus.start = (h == 1);
            bus.op_x  = 32'd5;
            bus.op_y  = 32'd5;
            @(negedge clock);
            chk("valid_hold", bus.res_valid, 1);
            chk("result_hold", bus.result, exp_res);
        end
        bus.start     = 1'b1;
        bus.res_ready = 1'b1;
        @(negedge clock);
        bus.start     = 1'b0;
        bus.res_ready = 1'b0;
        chk("valid_exit", bus.res_valid, 0);
        chk("busy_exit", bus.busy, 0);
        $display("op x=%0d y=%0d -> result=%0d err=%0b steps=%0d", x, y, bus.result, err_obs, exp_k);
    endtask

    initial begin
        logic [31:0] rx, ry;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.op_x      = '0;
        bus.op_y      = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_a", A, 0);
        chk("rst_b", B, 0);
        chk("rst_result", bus.result, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Abort mid-RUN with an asynchronous reset.
        bus.start = 1'b1;
        bus.op_x  = 32'd100;
        bus.op_y  = 32'd75;
        @(negedge clock);
        bus.start = 1'b0;
        chk("mid_busy", bus.busy, 1);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.res_valid, 0);
        chk("abort_a", A, 0);
        chk("abort_b", B, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("abort_idle", bus.busy, 0);
        $display("reset abort checked");

        run_op(32'd12, 32'd8, 0);
        run_op(32'd7, 32'd0, 0);
        run_op(32'd0, 32'd0, 0);
        run_op(32'd21, 32'd21, 5);
        run_op(32'd1071, 32'd462, 0);
        run_op(32'd1071, 32'd462, 1);
        run_op(32'd100, 32'd1, 0);
        run_op(32'd6, 32'd4, 0);
        run_op(32'd0, 32'd9, 0);
        for (int i = 0; i < 20; i++) begin
            rx = $urandom_range(0, 300);
            ry = (i % 5 == 0) ? 32'd0 : $urandom_range(0, 300);
            run_op(rx, ry, i % 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gcd_sub_ctrl.md
Name: gcd_sub_ctrl

Overview:
- Control-and-register stage that sits upstream of the A/B add/sub datapath (inputs wea, web, mux1, mux2, aluctl, X, Y, A, B; outputs newA, newB).
- Owns the A and B registers and feeds them to the datapath. Registers newA/newB back on every clock edge.
- Sequences an unsigned GCD by repeated subtraction and swap.
- Accepts operands with a start pulse. Presents the result with a valid/ready handshake.

Parameters:
- N, 32: operand, register and result width.
- MAX_ITER, 1024: RUN-cycle limit; used only when GCD_ITER_LIMIT_EN is defined.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_x  in  N  first operand; must be valid while start=1.
- op_y  in  N  second operand; must be valid while start=1.
- busy  out  1  high when state is not IDLE.
- res_valid  out  1  result available (state DONE).
- res_ready  in  1  consumer accepts result.
- result  out  N  GCD; stable while res_valid=1.
- wea, web, mux1, mux2, aluctl  out  1 each  control word to the datapath.
- X, Y  out  N  load/swap values to the datapath.
- A, B  out  N  current register contents to the datapath.
- newA, newB  in  N  next register values from the datapath.

Behaviour:
- Interface fact: one clock; reset is asynchronous and active-low.
- Datapath semantics:
  - wea=0 holds A; wea=1, mux1=0 loads X; wea=1, mux1=1 loads the ALU result (aluctl=0 gives A+B, 1 gives A-B). web, mux2 act the same on B, with Y.
  - On each rising edge: A<=newA, B<=newB.
- Reset (asynchronous, reset_n=0): state=IDLE; A=B=0; result=0; res_valid=0; busy=0. Reset mid-operation aborts immediately; no result is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - Drives X=op_x, Y=op_y, mux1=mux2=0, aluctl=0, wea=web=start.
  - On start=1: A,B load the operands at that edge; go to RUN.
- RUN: one step per cycle, decided combinationally from the registered A,B (unsigned).
  - Terminal, when A==0, B==0 or A==B: wea=web=0; result<=A|B; go to DONE. This yields gcd(a,0)=a, gcd(0,0)=0 and gcd(a,a)=a.
  - A>B (subtract): wea=1, mux1=1, aluctl=1, web=0; A<=A-B.
  - A<B (swap): wea=web=1, mux1=mux2=0, X=B, Y=A.
  - A-B never underflows, because subtract is issued only when A>B.
- DONE:
  - res_valid=1; all write enables 0; result held.
  - res_ready=1: go to IDLE and deassert res_valid next cycle.
  - start is ignored in DONE, including when it coincides with res_ready. It is accepted only in IDLE.
- Latency: start edge, then k RUN cycles, then res_valid on the cycle after the terminal RUN cycle. k counts the subtract/swap steps plus the terminal check.
- Unused control outputs are driven 0; X and Y are driven 0 outside IDLE and swap.

Optional Feature:
- Macro: GCD_ITER_LIMIT_EN.
- Defined:
  - Adds output port err (1 bit) and a RUN cycle counter of width $clog2(MAX_ITER+1). The counter clears on start.
  - If the counter reaches MAX_ITER without hitting the terminal case: go to DONE with result=0, err=1.
  - err is cleared on the next start and by reset.
- Undefined: no counter, no err port; RUN continues until the terminal case (up to about 2^N cycles).

Decomposition:
- Package gcd_pkg:
  - state enum {IDLE, RUN, DONE};
  - packed struct ctrl_word_t {wea, web, mux1, mux2, aluctl};
  - constants CTRL_HOLD, CTRL_LOAD, CTRL_SUB, CTRL_SWAP.
- One natural sub-module: gcd_step_dec.
  - Combinational; maps (A, B) to {terminal, ctrl_word_t, X/Y select}.
  - Instantiated once, in RUN.

Test Plan:
- Reset mid-RUN, with op_x=100, op_y=75 loaded: assert reset_n=0 for 1 cycle -> busy=0, res_valid=0, A=B=0, state IDLE.
- start with op_x=12, op_y=8 -> RUN steps are sub(A=4), swap(A=8,B=4), sub(A=4), terminal; res_valid on the 5th cycle after the start edge; result=4.
- op_x=7, op_y=0 -> one terminal RUN cycle; result=7. Then op_x=0, op_y=0 -> result=0.
- op_x=21, op_y=21 -> immediate terminal; result=21. With res_ready held 0 for 5 cycles, res_valid and result stay stable. start pulsed during DONE is ignored; res_ready=1 returns to IDLE.
- op_x=1071, op_y=462 -> result=21; busy high from the cycle after the start edge until DONE exits; back-to-back start the cycle after IDLE re-entry is accepted.
- With GCD_ITER_LIMIT_EN and MAX_ITER=4, op_x=100, op_y=1 -> after 4 RUN cycles: err=1, result=0. The next start with op_x=6, op_y=4 clears err; result=2.
